// File: rtl/pipelined_control_unit_if.sv
// pipelined_control_unit_if: IF/ID instruction and freeze inputs plus per-stage control outputs.
interface pipelined_control_unit_if #(
    parameter int INSTR_W = 32,
    parameter int REG_AW  = 5,
    parameter int CW_W    = 15
);
    logic [INSTR_W-1:0] instruction;
    logic               ext_stall;
    logic [CW_W-1:0]    ex_ctrl, mem_ctrl, wb_ctrl;
    logic [REG_AW-1:0]  ex_dest, mem_dest, wb_dest;
    logic               pc_ld, ifid_ld, hazard_stall;
    logic [1:0]         fwd_a_sel, fwd_b_sel;
    modport master (
        output instruction, ext_stall,
        input  ex_ctrl, mem_ctrl, wb_ctrl, ex_dest, mem_dest, wb_dest,
        input  pc_ld, ifid_ld, hazard_stall, fwd_a_sel, fwd_b_sel
    );
    modport slave (
        input  instruction, ext_stall,
        output ex_ctrl, mem_ctrl, wb_ctrl, ex_dest, mem_dest, wb_dest,
        output pc_ld, ifid_ld, hazard_stall, fwd_a_sel, fwd_b_sel
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: MIPS decode, EX/MEM/WB control registers and hazard stall/bubble control.
// Define FORWARDING_EN to forward ALU results instead of stalling on RAW dependencies.
module pipelined_control_unit #(
    parameter int INSTR_W    = 32,
    parameter int REG_AW     = 5,
    parameter int CW_W       = 15,
    parameter int MULDIV_LAT = 4
) (
    input logic clk,
    input logic reset,
    pipelined_control_unit_if.slave bus
);
    localparam logic [5:0] OP_ADDIU = 6'b001001, OP_LBU = 6'b100100, OP_SB = 6'b101000;
    localparam logic [5:0] OP_BGTZ = 6'b000111, OP_JAL = 6'b000011, OP_LUI = 6'b001111;
    logic [5:0]        op, funct;
    logic [REG_AW-1:0] rs, rt, rd, id_dest;
    logic [CW_W-1:0]   id_ctrl;
    logic              r_type, is_muldiv, is_mf, known, use_rs, use_rt;
    logic              ex_hit, mem_hit, load_use, raw, busy, hazard;
    logic [1:0]        fwd_a_nxt, fwd_b_nxt;
    logic [CW_W-1:0]   ex_ctrl, mem_ctrl, wb_ctrl;
    logic [REG_AW-1:0] ex_dest, mem_dest, wb_dest;
    logic [1:0]        fwd_a, fwd_b;
    logic [3:0]        cnt;
    // ctrl bits: 14 shift_imm, 13:11 alu_op, 10 load, 9 rf_en, 8 b, 7 ta, 6:5 size, 4 rw, 3 se, 2 hi, 1 lo, 0 mem_en
    always_comb begin
        op        = bus.instruction[31:26];
        funct     = bus.instruction[5:0];
        rs        = bus.instruction[21 +: REG_AW];
        rt        = bus.instruction[16 +: REG_AW];
        rd        = bus.instruction[11 +: REG_AW];
        r_type    = op == 6'b000000;
        is_muldiv = r_type && funct[5:2] == 4'b0110;
        is_mf     = r_type && (funct == 6'b010000 || funct == 6'b010010);
        id_ctrl   = r_type ? (is_muldiv ? 15'h0006 : funct == 6'b100011 ? 15'h1200 : 15'h0200) :
                    op == OP_ADDIU ? 15'h4A00 :
                    op == OP_LBU   ? 15'h0601 :
                    op == OP_SB    ? 15'h0011 :
                    op == OP_BGTZ  ? 15'h0100 :
                    op == OP_JAL   ? 15'h0280 :
                    op == OP_LUI   ? 15'h0200 : 15'h0000;
        known     = r_type || op == OP_ADDIU || op == OP_LBU || op == OP_SB || op == OP_BGTZ ||
                    op == OP_JAL || op == OP_LUI;
        use_rs    = known && op != OP_JAL && op != OP_LUI;
        use_rt    = r_type || op == OP_SB;
        id_dest   = !id_ctrl[9] ? '0 : r_type ? rd : op == OP_JAL ? REG_AW'(31) : rt;
        ex_hit    = ex_dest != '0 && ((use_rs && ex_dest == rs) || (use_rt && ex_dest == rt));
        mem_hit   = mem_dest != '0 && ((use_rs && mem_dest == rs) || (use_rt && mem_dest == rt));
        load_use  = ex_ctrl[10] && ex_hit;
        busy      = (is_muldiv || is_mf) && cnt != 4'd0;
`ifdef FORWARDING_EN
        raw       = 1'b0;
        // EX result will sit in EX/MEM and MEM result in MEM/WB once this instruction reaches EX
        fwd_a_nxt = (ex_ctrl[9] && !ex_ctrl[10] && rs != '0 && ex_dest == rs) ? 2'd1 :
                    (mem_ctrl[9] && rs != '0 && mem_dest == rs) ? 2'd2 : 2'd0;
        fwd_b_nxt = (ex_ctrl[9] && !ex_ctrl[10] && rt != '0 && ex_dest == rt) ? 2'd1 :
                    (mem_ctrl[9] && rt != '0 && mem_dest == rt) ? 2'd2 : 2'd0;
`else
        raw       = (ex_ctrl[9] && ex_hit) || (mem_ctrl[9] && mem_hit);
        fwd_a_nxt = 2'd0;
        fwd_b_nxt = 2'd0;
`endif
        hazard    = load_use || raw || busy;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            ex_ctrl  <= '0;
            mem_ctrl <= '0;
            wb_ctrl  <= '0;
            ex_dest  <= '0;
            mem_dest <= '0;
            wb_dest  <= '0;
            fwd_a    <= 2'd0;
            fwd_b    <= 2'd0;
            cnt      <= 4'd0;
        end else if (!bus.ext_stall) begin
            ex_ctrl  <= hazard ? '0 : id_ctrl;
            ex_dest  <= hazard ? '0 : id_dest;
            mem_ctrl <= ex_ctrl;
            mem_dest <= ex_dest;
            wb_ctrl  <= mem_ctrl;
            wb_dest  <= mem_dest;
            fwd_a    <= hazard ? 2'd0 : fwd_a_nxt;
            fwd_b    <= hazard ? 2'd0 : fwd_b_nxt;
            cnt      <= (!hazard && is_muldiv) ? 4'(MULDIV_LAT) : cnt - {3'b0, cnt != 4'd0};
        end
    assign bus.ex_ctrl      = ex_ctrl;
    assign bus.mem_ctrl     = mem_ctrl;
    assign bus.wb_ctrl      = wb_ctrl;
    assign bus.ex_dest      = ex_dest;
    assign bus.mem_dest     = mem_dest;
    assign bus.wb_dest      = wb_dest;
    assign bus.fwd_a_sel    = fwd_a;
    assign bus.fwd_b_sel    = fwd_b;
    assign bus.hazard_stall = reset && !bus.ext_stall && hazard;
    assign bus.pc_ld        = reset && !bus.ext_stall && !hazard;
    assign bus.ifid_ld      = bus.pc_ld;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: directed checks of decode, stage advance, hazards, ext_stall and reset.
module tb_pipelined_control_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   n;
    localparam logic [31:0] NOP = 32'hFC00_0000;
    localparam logic [31:0] TI [5] = '{32'hA000_0004, 32'h1C00_0002, 32'h0C00_0010,
                                       32'h3C09_1234, 32'h0000_001B};
    localparam logic [14:0] TC [5] = '{15'h0011, 15'h0100, 15'h0280, 15'h0200, 15'h0006};
    localparam logic [4:0]  TD [5] = '{5'd0, 5'd0, 5'd31, 5'd9, 5'd0};
    pipelined_control_unit_if #(.INSTR_W(32), .REG_AW(5), .CW_W(15)) bus ();
    pipelined_control_unit #(.INSTR_W(32), .REG_AW(5), .CW_W(15), .MULDIV_LAT(4)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [31:0] rt_i(input logic [4:0] s, t, d, input logic [5:0] f);
        return {6'b0, s, t, d, 5'b0, f};
    endfunction
    function automatic logic [31:0] it_i(input logic [5:0] o, input logic [4:0] s, t, input logic [15:0] imm);
        return {o, s, t, imm};
    endfunction
    initial begin
        bus.instruction = NOP;
        bus.ext_stall   = 1'b0;
        tick();
        tick();
        chk("rst_ex_ctrl", bus.ex_ctrl, 0);
        chk("rst_wb_dest", bus.wb_dest, 0);
        chk("rst_pc_ld", bus.pc_ld, 0);
        chk("rst_ifid_ld", bus.ifid_ld, 0);
        reset = 1'b1;
        #1;
        chk("rel_pc_ld", bus.pc_ld, 1);
        // ADDIU $3,$0,5 then SUBU $4,$3,$3
        bus.instruction = it_i(6'b001001, 5'd0, 5'd3, 16'd5);
        #1;
        chk("addiu_nostall", bus.hazard_stall, 0);
        tick();
        chk("addiu_ctrl", bus.ex_ctrl, 15'h4A00);
        chk("addiu_dest", bus.ex_dest, 3);
        bus.instruction = rt_i(5'd3, 5'd3, 5'd4, 6'b100011);
        #1;
`ifdef FORWARDING_EN
        chk("subu_nostall", bus.hazard_stall, 0);
        tick();
        chk("subu_ctrl", bus.ex_ctrl, 15'h1200);
        chk("subu_fwd_a", bus.fwd_a_sel, 1);
        chk("subu_fwd_b", bus.fwd_b_sel, 1);
`else
        chk("subu_stall1", bus.hazard_stall, 1);
        chk("subu_pc_ld1", bus.pc_ld, 0);
        tick();
        chk("subu_bubble1", bus.ex_ctrl, 0);
        chk("subu_mem_adv", bus.mem_ctrl, 15'h4A00);
        chk("subu_stall2", bus.hazard_stall, 1);
        tick();
        chk("subu_bubble2", bus.ex_ctrl, 0);
        chk("subu_wb_adv", bus.wb_ctrl, 15'h4A00);
        chk("subu_stall3", bus.hazard_stall, 0);
        tick();
        chk("subu_ctrl", bus.ex_ctrl, 15'h1200);
        chk("subu_fwd_a", bus.fwd_a_sel, 0);
`endif
        chk("subu_dest", bus.ex_dest, 4);
        // unknown opcode
        bus.instruction = NOP;
        #1;
        chk("unk_nostall", bus.hazard_stall, 0);
        tick();
        chk("unk_ctrl", bus.ex_ctrl, 0);
        chk("unk_dest", bus.ex_dest, 0);
        chk("unk_mem", bus.mem_ctrl, 15'h1200);
        // LBU $5 then ADDU $6,$5,$7
        bus.instruction = it_i(6'b100100, 5'd0, 5'd5, 16'd0);
        tick();
        chk("lbu_ctrl", bus.ex_ctrl, 15'h0601);
        chk("lbu_dest", bus.ex_dest, 5);
        bus.instruction = rt_i(5'd5, 5'd7, 5'd6, 6'b100001);
        #1;
        chk("lu_stall", bus.hazard_stall, 1);
        chk("lu_ifid_ld", bus.ifid_ld, 0);
        tick();
        chk("lu_bubble", bus.ex_ctrl, 0);
`ifndef FORWARDING_EN
        chk("lu_raw_stall", bus.hazard_stall, 1);
        tick();
`endif
        chk("lu_release", bus.hazard_stall, 0);
        tick();
        chk("addu_ctrl", bus.ex_ctrl, 15'h0200);
        chk("addu_dest", bus.ex_dest, 6);
`ifdef FORWARDING_EN
        chk("addu_fwd_a", bus.fwd_a_sel, 2);
`else
        chk("addu_fwd_a", bus.fwd_a_sel, 0);
`endif
        // ext_stall during a load-use stall
        bus.instruction = NOP;
        repeat (3) tick();
        bus.instruction = it_i(6'b100100, 5'd0, 5'd5, 16'd0);
        tick();
        bus.instruction = rt_i(5'd5, 5'd7, 5'd6, 6'b100001);
        bus.ext_stall = 1'b1;
        #1;
        chk("ext_hz", bus.hazard_stall, 0);
        chk("ext_pc_ld", bus.pc_ld, 0);
        tick();
        chk("ext_hold_ex", bus.ex_ctrl, 15'h0601);
        chk("ext_hold_mem", bus.mem_ctrl, 0);
        tick();
        chk("ext_hold_ex2", bus.ex_dest, 5);
        bus.ext_stall = 1'b0;
        #1;
        chk("ext_rel_hz", bus.hazard_stall, 1);
        tick();
        chk("ext_bubble", bus.ex_ctrl, 0);
        chk("ext_mem_adv", bus.mem_ctrl, 15'h0601);
`ifndef FORWARDING_EN
        tick();
`endif
        tick();
        chk("ext_addu", bus.ex_ctrl, 15'h0200);
        // MULT then MFLO
        bus.instruction = NOP;
        repeat (3) tick();
        bus.instruction = rt_i(5'd1, 5'd2, 5'd0, 6'b011000);
        #1;
        chk("mult_nostall", bus.hazard_stall, 0);
        tick();
        chk("mult_ctrl", bus.ex_ctrl, 15'h0006);
        chk("mult_dest", bus.ex_dest, 0);
        bus.instruction = rt_i(5'd0, 5'd0, 5'd8, 6'b010010);
        #1;
        n = 0;
        for (int i = 0; i < 10 && !bus.pc_ld; i++) begin
            n++;
            tick();
        end
        chk("mflo_stall_cycles", n, 4);
        chk("mflo_release", bus.hazard_stall, 0);
        tick();
        chk("mflo_ctrl", bus.ex_ctrl, 15'h0200);
        chk("mflo_dest", bus.ex_dest, 8);
        // remaining decodes: SB, BGTZ, JAL, LUI, DIVU
        for (int i = 0; i < 5; i++) begin
            bus.instruction = TI[i];
            #1;
            chk("tbl_nostall", bus.hazard_stall, 0);
            tick();
            chk("tbl_ctrl", bus.ex_ctrl, TC[i]);
            chk("tbl_dest", bus.ex_dest, TD[i]);
        end
        // DIV behind DIVU stalls; reset asserted mid-stall
        bus.instruction = rt_i(5'd0, 5'd0, 5'd0, 6'b011010);
        #1;
        chk("div_busy", bus.hazard_stall, 1);
        reset = 1'b0;
        #1;
        chk("arst_ex", bus.ex_ctrl, 0);
        chk("arst_mem", bus.mem_ctrl, 0);
        chk("arst_wb", bus.wb_ctrl, 0);
        chk("arst_wb_dest", bus.wb_dest, 0);
        chk("arst_pc_ld", bus.pc_ld, 0);
        chk("arst_hz", bus.hazard_stall, 0);
        repeat (3) tick();
        chk("arst_hold_pc_ld", bus.pc_ld, 0);
        chk("arst_hold_ex", bus.ex_ctrl, 0);
        reset = 1'b1;
        #1;
        chk("arel_pc_ld", bus.pc_ld, 1);
        tick();
        chk("div_ctrl", bus.ex_ctrl, 15'h0006);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
